// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared CPU constants used by the HI/LO multiply sequencer and its multiplier.
package mul_hilo_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/mul_hilo_ctrl_mul.sv
// Combinational 32x32 multiplier MUL; returns the low 64 bits of the
// sign- or zero-extended product.
module MUL
  import mul_hilo_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  input  logic                i_signed,
  output logic [2*DATA_W-1:0] o_product
);

  logic [2*DATA_W-1:0] w_aExt;
  logic [2*DATA_W-1:0] w_bExt;

  // The low 64 bits of a 64x64 product are the same whether the extended
  // operands are viewed as signed or unsigned, so one multiplier serves both.
  assign w_aExt    = i_signed ? {{DATA_W{i_a[DATA_W-1]}}, i_a} : {{DATA_W{1'b0}}, i_a};
  assign w_bExt    = i_signed ? {{DATA_W{i_b[DATA_W-1]}}, i_b} : {{DATA_W{1'b0}}, i_b};
  assign o_product = w_aExt * w_bExt;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO sequencer: latches MULT/MULTU operands, holds them for a fixed
// multicycle window, then writes the product to HI/LO. Also handles MTHI/MTLO.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sign_flag,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic                r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_sign;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;
  logic [2*DATA_W-1:0] w_product;

  // Fed only from the latched operands so the multiplier sees stable inputs
  // for the whole busy window (multicycle path).
  MUL u_mul (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_signed  (r_sign),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // MT writes land first; a simultaneous multiply overwrites them later.
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_sign  <= sign_flag;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= ST_BUSY;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            r_hi    <= w_product[2*DATA_W-1:DATA_W];
            r_lo    <= w_product[DATA_W-1:0];
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy = (r_state == ST_BUSY);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: directed cases plus random multiplies
// checked against an arithmetic reference of the HI/LO contents.
module tb_mul_hilo_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign_flag;
  logic [31:0] A;
  logic [31:0] B;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] expHi;
  logic [31:0] expLo;

  mul_hilo_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_flag (sign_flag),
    .A         (A),
    .B         (B),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Reference product: plain integer arithmetic, low 64 bits kept.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    sign_flag = s;
    A         = a;
    B         = b;
  endtask

  // Starts a multiply in the current cycle and follows it to its done cycle,
  // checking busy/done/HI/LO against the model along the way.
  task automatic runMult(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
    logic [63:0] p;
    p = refProduct(a, b, s);
    applyStimulus(s, a, b);
    tick();
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    sign_flag = ~s;
    checkOutput({tag, ".busy0"}, 64'(busy), 64'd1);
    for (int k = 1; k < LAT; k++) begin
      tick();
      checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
      checkOutput({tag, ".doneLow"}, 64'(done), 64'd0);
      checkOutput({tag, ".hold"}, {hi, lo}, {expHi, expLo});
    end
    tick();
    expHi = p[63:32];
    expLo = p[31:0];
    checkOutput({tag, ".busyEnd"}, 64'(busy), 64'd0);
    checkOutput({tag, ".done"}, 64'(done), 64'd1);
    checkOutput({tag, ".hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, ".lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    rst = 1'b1; start = 1'b0; sign_flag = 1'b0; A = '0; B = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    expHi = '0; expLo = '0;
    tick();
    tick();
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();

    // Unsigned max operands
    runMult("umax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("umax.hiConst", 64'(hi), 64'hFFFFFFFE);
    checkOutput("umax.loConst", 64'(lo), 64'h00000001);
    tick();
    checkOutput("umax.donePulse", 64'(done), 64'd0);

    // Signed cases
    runMult("sneg", 1'b1, 32'hFFFFFFFE, 32'd3);
    checkOutput("sneg.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    tick();
    runMult("sm1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("sm1.const", {hi, lo}, 64'h00000000_00000001);
    tick();

    // MTHI / MTLO in IDLE
    mthi = 1'b1; wdata = 32'h12345678;
    tick();
    mthi = 1'b0;
    expHi = 32'h12345678;
    checkOutput("mthi.hi", 64'(hi), 64'h12345678);
    checkOutput("mthi.busy", 64'(busy), 64'd0);
    mtlo = 1'b1; wdata = 32'h9ABCDEF0;
    tick();
    mtlo = 1'b0;
    expLo = 32'h9ABCDEF0;
    checkOutput("mtlo.lo", 64'(lo), 64'h9ABCDEF0);
    checkOutput("mtlo.hiHeld", 64'(hi), 64'h12345678);
    checkOutput("mtlo.busy", 64'(busy), 64'd0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    expHi = 32'h0BADF00D; expLo = 32'h0BADF00D;
    checkOutput("mtboth", {hi, lo}, {expHi, expLo});

    // Operand stability and start/mthi ignored while busy
    applyStimulus(1'b0, 32'd5, 32'd7);
    tick();
    start = 1'b0;
    tick();
    A = 32'd9; B = 32'd9; start = 1'b1; mthi = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0; mthi = 1'b0;
    checkOutput("stab.hiNoMt", 64'(hi), 64'(expHi));
    tick();
    checkOutput("stab.busy", 64'(busy), 64'd1);
    tick();
    checkOutput("stab.done", 64'(done), 64'd1);
    checkOutput("stab.result", {hi, lo}, 64'd35);
    expHi = 32'd0; expLo = 32'd35;
    tick();
    checkOutput("stab.noSecondBusy", 64'(busy), 64'd0);
    checkOutput("stab.doneLow", 64'(done), 64'd0);
    tick();
    checkOutput("stab.stillIdle", 64'(busy), 64'd0);

    // Start together with MTHI: MT applied, then overwritten by product
    mthi = 1'b1; wdata = 32'hCAFEF00D;
    expHi = 32'hCAFEF00D;
    applyStimulus(1'b0, 32'd11, 32'd13);
    tick();
    mthi = 1'b0; start = 1'b0;
    checkOutput("mtstart.hi", 64'(hi), 64'hCAFEF00D);
    for (int k = 1; k < LAT; k++) tick();
    tick();
    checkOutput("mtstart.result", {hi, lo}, 64'd143);
    expHi = 32'd0; expLo = 32'd143;

    // Back-to-back multiplies: start in the done cycle
    runMult("b2b1", 1'b0, 32'd10, 32'd10);
    runMult("b2b2", 1'b0, 32'd2, 32'd3);
    checkOutput("b2b2.const", {hi, lo}, 64'd6);
    tick();

    // Random multiplies with occasional MT writes in between
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        mtlo = 1'b1; wdata = $urandom;
        expLo = wdata;
        tick();
        mtlo = 1'b0;
        checkOutput("rand.mtlo", 64'(lo), 64'(expLo));
      end
      runMult("rand", rs, ra, rb);
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();

    // Reset mid-operation
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55AA55AA;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("rstmid.preload", {hi, lo}, 64'h55AA55AA_55AA55AA);
    applyStimulus(1'b0, 32'd3, 32'd4);
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid.busy", 64'(busy), 64'd0);
    checkOutput("rstmid.done", 64'(done), 64'd0);
    checkOutput("rstmid.hilo", {hi, lo}, 64'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      checkOutput("rstmid.noWrite", {hi, lo}, 64'd0);
      checkOutput("rstmid.noDone", 64'(done), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
